// File: rtl/ysyx_csr_file_if.sv
// CSR access, trap/mret control and registered status outputs between core and CSR file.
interface ysyx_csr_file_if #(
  parameter int XLEN = 32
);
  logic            csr_valid;
  logic [1:0]      csr_op;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] rdata_o;
  logic            illegal_o;
  logic            trap_en;
  logic [XLEN-1:0] trap_cause;
  logic [XLEN-1:0] trap_pc;
  logic            mret_en;
  logic            retire;
  logic [XLEN-1:0] mtvec_o;
  logic [XLEN-1:0] mepc_o;
  logic            mie_o;

  modport master (
    output csr_valid, csr_op, csr_addr, csr_wdata,
    output trap_en, trap_cause, trap_pc, mret_en, retire,
    input  rdata_o, illegal_o, mtvec_o, mepc_o, mie_o
  );

  modport slave (
    input  csr_valid, csr_op, csr_addr, csr_wdata,
    input  trap_en, trap_cause, trap_pc, mret_en, retire,
    output rdata_o, illegal_o, mtvec_o, mepc_o, mie_o
  );
endinterface

// File: rtl/ysyx_csr_file.sv
// Machine-mode CSR file: mstatus/trap state, 64-bit cycle and instret counters,
// read-only vendor/arch IDs; reads are combinational, all updates on posedge clk.
module ysyx_csr_file #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] MTVEC_RST = '0,
  parameter logic [31:0]     MVENDORID = 32'h79737978,
  parameter logic [31:0]     MARCHID   = 32'h015fde77
) (
  input  logic           clk,
  input  logic           rst,
  ysyx_csr_file_if.slave bus
);
  localparam logic [11:0] A_MSTATUS   = 12'h300, A_MTVEC    = 12'h305,
                          A_MSCRATCH  = 12'h340, A_MEPC     = 12'h341,
                          A_MCAUSE    = 12'h342, A_MCYCLE   = 12'hB00,
                          A_MINSTRET  = 12'hB02, A_MCYCLEH  = 12'hB80,
                          A_MINSTRETH = 12'hB82, A_MVENDOR  = 12'hF11,
                          A_MARCHID   = 12'hF12;
  localparam logic [1:0]  OP_RW = 2'b01, OP_RS = 2'b10, OP_RC = 2'b11;

  logic            mie_q, mie_d, mpie_q, mpie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d;
  logic [63:0]     mcycle_q, mcycle_d, minstret_q, minstret_d;

  logic [XLEN-1:0] mstatus_rd, rdata, wval;
  logic [63:0]     wval64, cyc_inc, ins_inc;
  logic            impl, wr_req, illegal, wr_en;

  // Read mux and access legality; rdata is the pre-update value used as the RS/RC base
  always_comb begin
    mstatus_rd        = '0;
    mstatus_rd[12:11] = 2'b11;
    mstatus_rd[7]     = mpie_q;
    mstatus_rd[3]     = mie_q;
    rdata = '0;
    impl  = 1'b1;
    case (bus.csr_addr)
      A_MSTATUS:   rdata = mstatus_rd;
      A_MTVEC:     rdata = mtvec_q;
      A_MSCRATCH:  rdata = mscratch_q;
      A_MEPC:      rdata = mepc_q;
      A_MCAUSE:    rdata = mcause_q;
      A_MCYCLE:    rdata = mcycle_q[XLEN-1:0];
      A_MINSTRET:  rdata = minstret_q[XLEN-1:0];
      A_MCYCLEH:   if (XLEN == 32) rdata = XLEN'(mcycle_q[63:32]);   else impl = 1'b0;
      A_MINSTRETH: if (XLEN == 32) rdata = XLEN'(minstret_q[63:32]); else impl = 1'b0;
      A_MVENDOR:   rdata = XLEN'(MVENDORID);
      A_MARCHID:   rdata = XLEN'(MARCHID);
      default:     impl  = 1'b0;
    endcase

    // Set/clear with a zero mask is a pure read, so it may target read-only IDs
    wr_req  = bus.csr_valid &&
              (bus.csr_op == OP_RW || (bus.csr_op != 2'b00 && bus.csr_wdata != '0));
    illegal = bus.csr_valid &&
              (!impl || (wr_req && (bus.csr_addr == A_MVENDOR || bus.csr_addr == A_MARCHID)));
    wr_en   = wr_req && !illegal;

    case (bus.csr_op)
      OP_RW:   wval = bus.csr_wdata;
      OP_RS:   wval = rdata | bus.csr_wdata;
      OP_RC:   wval = rdata & ~bus.csr_wdata;
      default: wval = rdata;
    endcase
    wval64 = 64'(wval);
  end

  // Next-state: counters and non-trap CSRs, then trap > mret > CSR write for mstatus/mepc/mcause
  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    cyc_inc    = mcycle_q + 64'd1;
    ins_inc    = minstret_q + 64'(bus.retire);
    mcycle_d   = cyc_inc;
    minstret_d = ins_inc;

    // A half-write replaces only that half; the other half keeps the carry from the old value
    if (wr_en) begin
      case (bus.csr_addr)
        A_MTVEC:     mtvec_d    = wval;
        A_MSCRATCH:  mscratch_d = wval;
        A_MCYCLE:    mcycle_d   = (XLEN == 32) ? {cyc_inc[63:32], wval64[31:0]} : wval64;
        A_MINSTRET:  minstret_d = (XLEN == 32) ? {ins_inc[63:32], wval64[31:0]} : wval64;
        A_MCYCLEH:   mcycle_d   = {wval64[31:0], cyc_inc[31:0]};
        A_MINSTRETH: minstret_d = {wval64[31:0], ins_inc[31:0]};
        default: ;
      endcase
    end

    if (bus.trap_en) begin
      mepc_d   = {bus.trap_pc[XLEN-1:2], 2'b00};
      mcause_d = bus.trap_cause;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (bus.mret_en) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (wr_en) begin
      case (bus.csr_addr)
        A_MSTATUS: begin
          mie_d  = wval[3];
          mpie_d = wval[7];
        end
        A_MEPC:   mepc_d   = {wval[XLEN-1:2], 2'b00};
        A_MCAUSE: mcause_d = wval;
        default: ;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  assign bus.rdata_o   = rdata;
  assign bus.illegal_o = illegal;
  assign bus.mtvec_o   = mtvec_q;
  assign bus.mepc_o    = mepc_q;
  assign bus.mie_o     = mie_q;
endmodule

// File: tb/tb_ysyx_csr_file.sv
// Bench for ysyx_csr_file (XLEN=32): directed scenarios plus randomized traffic
// checked against an architectural model of the machine-mode CSRs.
module tb_ysyx_csr_file;
  localparam int          XLEN      = 32;
  localparam logic [31:0] MTVEC_RST = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_csr_file_if #(.XLEN(XLEN)) bus ();
  ysyx_csr_file #(.XLEN(XLEN), .MTVEC_RST(MTVEC_RST)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp  = 0;
  int n_fail = 0;

  // Architectural model state
  logic        m_mie, m_mpie;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [63:0] m_mcycle, m_minstret;

  function automatic bit m_impl(input logic [11:0] a);
    return a inside {12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB02,
                     12'hB80, 12'hB82, 12'hF11, 12'hF12};
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 | (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'hB00: return m_mcycle[31:0];
      12'hB80: return m_mcycle[63:32];
      12'hB02: return m_minstret[31:0];
      12'hB82: return m_minstret[63:32];
      12'hF11: return 32'h79737978;
      12'hF12: return 32'h015fde77;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_wants_write();
    return bus.csr_valid && (bus.csr_op == 2'b01 || (bus.csr_op != 2'b00 && bus.csr_wdata != 0));
  endfunction

  function automatic bit m_illegal();
    return bus.csr_valid && (!m_impl(bus.csr_addr) ||
           (m_wants_write() && (bus.csr_addr == 12'hF11 || bus.csr_addr == 12'hF12)));
  endfunction

  always @(posedge clk) begin
    logic [63:0] cyc, ins;
    logic [31:0] old, nv;
    bit          wr;
    if (rst) begin
      m_mie = 0; m_mpie = 0; m_mtvec = MTVEC_RST; m_mscratch = 0;
      m_mepc = 0; m_mcause = 0; m_mcycle = 0; m_minstret = 0;
    end else begin
      cyc = m_mcycle + 64'd1;
      ins = m_minstret + (bus.retire ? 64'd1 : 64'd0);
      wr  = m_wants_write() && !m_illegal();
      old = m_read(bus.csr_addr);
      nv  = (bus.csr_op == 2'b01) ? bus.csr_wdata :
            (bus.csr_op == 2'b10) ? (old | bus.csr_wdata) : (old & ~bus.csr_wdata);
      if (wr) begin
        case (bus.csr_addr)
          12'h305: m_mtvec = nv;
          12'h340: m_mscratch = nv;
          12'hB00: cyc = (cyc & 64'hFFFF_FFFF_0000_0000) | 64'(nv);
          12'hB80: cyc = (cyc & 64'h0000_0000_FFFF_FFFF) | (64'(nv) << 32);
          12'hB02: ins = (ins & 64'hFFFF_FFFF_0000_0000) | 64'(nv);
          12'hB82: ins = (ins & 64'h0000_0000_FFFF_FFFF) | (64'(nv) << 32);
          default: ;
        endcase
      end
      if (bus.trap_en) begin
        m_mepc = bus.trap_pc & ~32'h3; m_mcause = bus.trap_cause; m_mpie = m_mie; m_mie = 0;
      end else if (bus.mret_en) begin
        m_mie = m_mpie; m_mpie = 1;
      end else if (wr) begin
        case (bus.csr_addr)
          12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
          12'h341: m_mepc = nv & ~32'h3;
          12'h342: m_mcause = nv;
          default: ;
        endcase
      end
      m_mcycle   = cyc;
      m_minstret = ins;
    end
  end

  task automatic idle();
    bus.csr_valid = 0; bus.csr_op = 0; bus.csr_addr = 0; bus.csr_wdata = 0;
    bus.trap_en = 0; bus.trap_cause = 0; bus.trap_pc = 0; bus.mret_en = 0; bus.retire = 0;
  endtask

  task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] w);
    bus.csr_valid = 1; bus.csr_op = op; bus.csr_addr = a; bus.csr_wdata = w;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [11:0] a, output logic [31:0] v);
    bus.csr_valid = 0; bus.csr_op = 0; bus.csr_addr = a;
    #1;
    v = bus.rdata_o;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    idle(); rst = 1;
    step(); step();
    rst = 0;
    #1;
    n_cmp++; if (bus.mtvec_o !== MTVEC_RST) begin n_fail++; $display("FAIL rst_mtvec got=%h exp=%h", bus.mtvec_o, MTVEC_RST); end
    n_cmp++; if (bus.mepc_o !== 32'h0) begin n_fail++; $display("FAIL rst_mepc got=%h exp=0", bus.mepc_o); end
    n_cmp++; if (bus.mie_o !== 1'b0) begin n_fail++; $display("FAIL rst_mie got=%b exp=0", bus.mie_o); end
    peek(12'h300, v);
    n_cmp++; if (v !== 32'h1800) begin n_fail++; $display("FAIL rst_mstatus got=%h exp=00001800", v); end
    peek(12'hB00, v);
    n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL rst_mcycle_hold got=%h exp=0", v); end
    step();
    peek(12'hB00, v);
    n_cmp++; if (v !== 32'h1) begin n_fail++; $display("FAIL mcycle_first got=%h exp=1", v); end
    step();
    peek(12'hB00, v);
    n_cmp++; if (v !== 32'h2) begin n_fail++; $display("FAIL mcycle_second got=%h exp=2", v); end
  endtask

  task automatic test_mtvec();
    idle(); csr(2'b01, 12'h305, 32'h80000101);
    #1;
    n_cmp++; if (bus.rdata_o !== MTVEC_RST) begin n_fail++; $display("FAIL mtvec_preread got=%h exp=%h", bus.rdata_o, MTVEC_RST); end
    n_cmp++; if (bus.illegal_o !== 1'b0) begin n_fail++; $display("FAIL mtvec_legal got=%b exp=0", bus.illegal_o); end
    step(); idle();
    n_cmp++; if (bus.mtvec_o !== 32'h80000101) begin n_fail++; $display("FAIL mtvec_rw got=%h exp=80000101", bus.mtvec_o); end
    csr(2'b11, 12'h305, 32'h1);
    step(); idle();
    n_cmp++; if (bus.mtvec_o !== 32'h80000100) begin n_fail++; $display("FAIL mtvec_rc got=%h exp=80000100", bus.mtvec_o); end
    csr(2'b10, 12'h305, 32'h30);
    step(); idle();
    n_cmp++; if (bus.mtvec_o !== 32'h80000130) begin n_fail++; $display("FAIL mtvec_rs got=%h exp=80000130", bus.mtvec_o); end
  endtask

  task automatic test_trap_mret();
    logic [31:0] v;
    idle(); csr(2'b01, 12'h300, 32'h8);
    step(); idle();
    n_cmp++; if (bus.mie_o !== 1'b1) begin n_fail++; $display("FAIL mie_set got=%b exp=1", bus.mie_o); end
    bus.trap_en = 1; bus.trap_pc = 32'h80000013; bus.trap_cause = 32'd11;
    step(); idle();
    n_cmp++; if (bus.mepc_o !== 32'h80000010) begin n_fail++; $display("FAIL trap_mepc got=%h exp=80000010", bus.mepc_o); end
    n_cmp++; if (bus.mie_o !== 1'b0) begin n_fail++; $display("FAIL trap_mie got=%b exp=0", bus.mie_o); end
    peek(12'h342, v);
    n_cmp++; if (v !== 32'd11) begin n_fail++; $display("FAIL trap_mcause got=%h exp=0000000b", v); end
    peek(12'h300, v);
    n_cmp++; if (v !== 32'h1880) begin n_fail++; $display("FAIL trap_mstatus got=%h exp=00001880", v); end
    idle(); bus.mret_en = 1;
    step(); idle();
    n_cmp++; if (bus.mie_o !== 1'b1) begin n_fail++; $display("FAIL mret_mie got=%b exp=1", bus.mie_o); end
    csr(2'b01, 12'h300, 32'hFFFF_FFFF);
    step(); idle();
    peek(12'h300, v);
    n_cmp++; if (v !== 32'h1888) begin n_fail++; $display("FAIL mstatus_mask got=%h exp=00001888", v); end
  endtask

  task automatic test_trap_vs_write();
    logic [31:0] v;
    idle(); csr(2'b01, 12'h341, 32'h1234);
    bus.trap_en = 1; bus.trap_pc = 32'h80000027; bus.trap_cause = 32'd7;
    step(); idle();
    n_cmp++; if (bus.mepc_o !== 32'h80000024) begin n_fail++; $display("FAIL trap_over_write got=%h exp=80000024", bus.mepc_o); end
    peek(12'h342, v);
    n_cmp++; if (v !== 32'd7) begin n_fail++; $display("FAIL trap_over_write_cause got=%h exp=7", v); end
    idle(); csr(2'b01, 12'h341, 32'h1237);
    step(); idle();
    n_cmp++; if (bus.mepc_o !== 32'h1234) begin n_fail++; $display("FAIL mepc_align got=%h exp=00001234", bus.mepc_o); end
  endtask

  task automatic test_counter_wrap();
    logic [31:0] lo, hi;
    idle(); csr(2'b01, 12'hB80, 32'hFFFF_FFFF);
    step(); idle(); csr(2'b01, 12'hB00, 32'hFFFF_FFFF);
    step(); idle();
    peek(12'hB00, lo); peek(12'hB80, hi);
    n_cmp++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL mcycle_max got=%h exp=ffffffffffffffff", {hi, lo}); end
    idle();
    step();
    peek(12'hB00, lo); peek(12'hB80, hi);
    n_cmp++; if ({hi, lo} !== 64'h0) begin n_fail++; $display("FAIL mcycle_wrap got=%h exp=0", {hi, lo}); end
    idle(); csr(2'b01, 12'hB82, 32'hFFFF_FFFF);
    step(); idle(); csr(2'b01, 12'hB02, 32'hFFFF_FFFF);
    step(); idle(); bus.retire = 1;
    step(); idle();
    peek(12'hB02, lo); peek(12'hB82, hi);
    n_cmp++; if ({hi, lo} !== 64'h0) begin n_fail++; $display("FAIL minstret_wrap got=%h exp=0", {hi, lo}); end
  endtask

  task automatic test_id_illegal();
    logic [31:0] v;
    idle(); csr(2'b01, 12'hF11, 32'h5);
    #1;
    n_cmp++; if (bus.illegal_o !== 1'b1) begin n_fail++; $display("FAIL id_write_illegal got=%b exp=1", bus.illegal_o); end
    n_cmp++; if (bus.rdata_o !== 32'h79737978) begin n_fail++; $display("FAIL id_write_rdata got=%h exp=79737978", bus.rdata_o); end
    step(); idle();
    peek(12'hF11, v);
    n_cmp++; if (v !== 32'h79737978) begin n_fail++; $display("FAIL id_unchanged got=%h exp=79737978", v); end
    csr(2'b10, 12'hF11, 32'h0);
    #1;
    n_cmp++; if (bus.illegal_o !== 1'b0) begin n_fail++; $display("FAIL id_rs0_legal got=%b exp=0", bus.illegal_o); end
    csr(2'b10, 12'hF12, 32'h1);
    #1;
    n_cmp++; if (bus.illegal_o !== 1'b1) begin n_fail++; $display("FAIL marchid_rs_illegal got=%b exp=1", bus.illegal_o); end
    n_cmp++; if (bus.rdata_o !== 32'h015fde77) begin n_fail++; $display("FAIL marchid_rdata got=%h exp=015fde77", bus.rdata_o); end
    csr(2'b00, 12'h7C0, 32'h0);
    #1;
    n_cmp++; if (bus.illegal_o !== 1'b1) begin n_fail++; $display("FAIL unimpl_illegal got=%b exp=1", bus.illegal_o); end
    n_cmp++; if (bus.rdata_o !== 32'h0) begin n_fail++; $display("FAIL unimpl_rdata got=%h exp=0", bus.rdata_o); end
    csr(2'b00, 12'hB80, 32'h0);
    #1;
    n_cmp++; if (bus.illegal_o !== 1'b0) begin n_fail++; $display("FAIL mcycleh_legal got=%b exp=0", bus.illegal_o); end
    step(); idle();
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    idle(); csr(2'b01, 12'h340, 32'hDEADBEEF);
    step(); idle(); csr(2'b01, 12'h300, 32'h8);
    step(); idle();
    for (int i = 0; i < 5; i++) begin bus.retire = 1; step(); end
    rst = 1; bus.retire = 1; bus.trap_en = 1; bus.trap_pc = 32'h8000_0040; bus.trap_cause = 32'd3;
    csr(2'b01, 12'h305, 32'h1234_5678);
    step(); step();
    rst = 0; idle();
    #1;
    n_cmp++; if (bus.mtvec_o !== MTVEC_RST) begin n_fail++; $display("FAIL midrst_mtvec got=%h exp=%h", bus.mtvec_o, MTVEC_RST); end
    n_cmp++; if (bus.mepc_o !== 32'h0) begin n_fail++; $display("FAIL midrst_mepc got=%h exp=0", bus.mepc_o); end
    n_cmp++; if (bus.mie_o !== 1'b0) begin n_fail++; $display("FAIL midrst_mie got=%b exp=0", bus.mie_o); end
    peek(12'h340, v);
    n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL midrst_mscratch got=%h exp=0", v); end
    peek(12'h342, v);
    n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL midrst_mcause got=%h exp=0", v); end
    peek(12'h300, v);
    n_cmp++; if (v !== 32'h1800) begin n_fail++; $display("FAIL midrst_mstatus got=%h exp=00001800", v); end
    peek(12'hB02, v);
    n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL midrst_minstret got=%h exp=0", v); end
    step();
    peek(12'hB02, v);
    n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL midrst_minstret_after got=%h exp=0", v); end
    peek(12'hB00, v);
    n_cmp++; if (v !== 32'h1) begin n_fail++; $display("FAIL midrst_mcycle got=%h exp=1", v); end
  endtask

  task automatic test_random();
    logic [11:0] pool [15];
    pool = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB02, 12'hB80,
             12'hB82, 12'hF11, 12'hF12, 12'h7C0, 12'h301, 12'h344, 12'h000};
    for (int i = 0; i < 400; i++) begin
      idle();
      rst = ($urandom_range(0, 99) == 0);
      bus.csr_valid  = ($urandom_range(0, 3) != 0);
      bus.csr_op     = 2'($urandom_range(0, 3));
      bus.csr_addr   = pool[$urandom_range(0, 14)];
      bus.csr_wdata  = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
      bus.trap_en    = ($urandom_range(0, 15) == 0);
      bus.trap_pc    = $urandom;
      bus.trap_cause = $urandom;
      bus.mret_en    = ($urandom_range(0, 15) == 0);
      bus.retire     = 1'($urandom_range(0, 1));
      #1;
      n_cmp++; if (bus.rdata_o !== m_read(bus.csr_addr)) begin n_fail++; $display("FAIL rnd_rdata[%0d] addr=%h got=%h exp=%h", i, bus.csr_addr, bus.rdata_o, m_read(bus.csr_addr)); end
      n_cmp++; if (bus.illegal_o !== m_illegal()) begin n_fail++; $display("FAIL rnd_illegal[%0d] addr=%h got=%b exp=%b", i, bus.csr_addr, bus.illegal_o, m_illegal()); end
      step();
      n_cmp++; if (bus.mtvec_o !== m_mtvec) begin n_fail++; $display("FAIL rnd_mtvec[%0d] got=%h exp=%h", i, bus.mtvec_o, m_mtvec); end
      n_cmp++; if (bus.mepc_o !== m_mepc) begin n_fail++; $display("FAIL rnd_mepc[%0d] got=%h exp=%h", i, bus.mepc_o, m_mepc); end
      n_cmp++; if (bus.mie_o !== m_mie) begin n_fail++; $display("FAIL rnd_mie[%0d] got=%b exp=%b", i, bus.mie_o, m_mie); end
    end
    rst = 0; idle();
  endtask

  initial begin
    test_reset();
    test_mtvec();
    test_trap_mret();
    test_trap_vs_write();
    test_counter_wrap();
    test_id_illegal();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
